// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EX issue logic, the iterative divider and the writeback side.
//   in_valid/in_ready  : operation offer / accept (in_op, in_src1, in_src2, in_rd qualify it)
//   out_valid/out_ready: result offer / take (out_result, out_rd qualify it)
// Modports:
//   master : issue/writeback side (drives requests and out_ready)
//   slave  : the divider (div_ctrl)
interface div_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider controller for the execute stage.
// Accepts one DIV/MOD/DIVU/MODU at a time, produces one quotient bit per BUSY cycle, applies
// sign correction in FIX and holds the result in DONE until the writeback side takes it.
//
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   flush  : pipeline flush, kills any operation in flight (highest priority)
//   bus    : div_ctrl_if.slave
//            in_op bit0 = remainder wanted, bit1 = unsigned (DIV=00 MOD=01 DIVU=10 MODU=11)
//            in_rd is carried unchanged to out_rd
//   busy   : high whenever not idle; drives the EX stall
//
// Parameters:
//   ITER   : quotient bits produced, one per BUSY cycle (32 for this core)
//
// Build option:
//   DIV_ZERO_FAST_EN : when defined, a zero divisor skips BUSY/FIX and goes straight to DONE
//                      with quotient 0xFFFFFFFF / remainder = raw dividend.
module div_ctrl #(
  parameter int unsigned ITER = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  div_ctrl_if.slave     bus,
  output logic          busy
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFix,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d;     // partial remainder
  logic [31:0]     dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [31:0]     dvs_q, dvs_d;     // divisor magnitude
  logic            rem_op_q, rem_op_d;
  logic            s1_q, s1_d;       // dividend negative (signed ops only)
  logic            s2_q, s2_d;       // divisor negative (signed ops only)
  logic [31:0]     res_q, res_d;
  logic [4:0]      rd_q, rd_d;

  // Operand sign and magnitude at accept time
  logic        in_signed;
  logic        in_neg1, in_neg2;
  logic [31:0] in_mag1, in_mag2;

  assign in_signed = ~bus.in_op[1];
  assign in_neg1   = in_signed & bus.in_src1[31];
  assign in_neg2   = in_signed & bus.in_src2[31];
  assign in_mag1   = in_neg1 ? (~bus.in_src1 + 32'd1) : bus.in_src1;
  assign in_mag2   = in_neg2 ? (~bus.in_src2 + 32'd1) : bus.in_src2;

  // One restoring step. The remainder can legitimately reach bit 31 (divisor up to 2^32-1),
  // so the shifted value keeps all 33 bits and the subtract is done in 34 bits.
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        qbit;
  logic        unused_diff_bit;

  assign shifted         = {rem_q, dvd_q[31]};
  assign diff            = {1'b0, shifted} - {2'b00, dvs_q};
  assign qbit            = ~diff[33];
  assign unused_diff_bit = diff[32];

  // Sign correction: quotient negative when operand signs differ, remainder follows dividend
  logic [31:0] q_fix, r_fix;

  assign q_fix = (s1_q ^ s2_q) ? (~dvd_q + 32'd1) : dvd_q;
  assign r_fix = s1_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_op_d = rem_op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    res_d    = res_q;
    rd_d     = rd_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && !flush) begin
          rem_op_d = bus.in_op[0];
          s1_d     = in_neg1;
          s2_d     = in_neg2;
          dvd_d    = in_mag1;
          dvs_d    = in_mag2;
          rem_d    = '0;
          cnt_d    = '0;
          rd_d     = bus.in_rd;
          state_d  = StBusy;
`ifdef DIV_ZERO_FAST_EN
          if (bus.in_src2 == 32'd0) begin
            res_d   = bus.in_op[0] ? bus.in_src1 : 32'hFFFF_FFFF;
            state_d = StDone;
          end
`endif
        end
      end

      StBusy: begin
        rem_d = qbit ? diff[31:0] : shifted[31:0];
        dvd_d = {dvd_q[30:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        res_d   = rem_op_q ? r_fix : q_fix;
        state_d = StDone;
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Flush overrides everything, including a same-cycle accept
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_op_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      res_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_op_q <= rem_op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_result = res_q;
  assign bus.out_rd     = rd_q;

endmodule
